// File: rtl/pipes_pkg.sv
// Shared pipeline types: bubble-injection control, hazard FSM states and
// the perf-counter width.
package pipes;

    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } hazard_state_t;

    // A load in EX whose (non-x0) destination is read by the ID instruction.
    function automatic logic is_load_use(
        input logic       ex_is_load,
        input logic       ex_regwrite,
        input logic [4:0] ex_dst,
        input logic       use_rs1,
        input logic [4:0] rs1,
        input logic       use_rs2,
        input logic [4:0] rs2
    );
        return ex_is_load && ex_regwrite && (ex_dst != 5'd0) &&
               ((use_rs1 && (rs1 == ex_dst)) || (use_rs2 && (rs2 == ex_dst)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/bubble generation, a RUN/SQUASH
// FSM that discards a fetch made stale by a redirect, and stall/flush counters.
module hazard_ctrl
    import pipes::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [4:0]            ex_dst,
    input  logic                  ex_is_load,
    input  logic                  ex_regwrite,
    input  logic                  branch_taken,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    output logic                  stall_pc,
    output logic                  stall_IF_ID,
    output logic                  stall_ID_EX,
    output logic                  stall_EX_MEM,
    output reset_t                reset_IF_ID,
    output reset_t                reset_ID_EX,
    output reset_t                reset_MEM_WB,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
);

    hazard_state_t state_q, state_d;
    logic          load_use;
    logic          flush_inc;

    assign load_use = is_load_use(ex_is_load, ex_regwrite, ex_dst,
                                  id_use_rs1, id_rs1, id_use_rs2, id_rs2);

    always_comb begin
        stall_pc     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        reset_IF_ID  = RESET_CONTINUE;
        reset_ID_EX  = RESET_CONTINUE;
        reset_MEM_WB = RESET_CONTINUE;
        if (reset) begin
            reset_IF_ID  = RESET_RESET;
            reset_ID_EX  = RESET_RESET;
            reset_MEM_WB = RESET_RESET;
        end else begin
            if (dmem_busy) begin
                stall_pc     = 1'b1;
                stall_IF_ID  = 1'b1;
                stall_ID_EX  = 1'b1;
                stall_EX_MEM = 1'b1;
                reset_MEM_WB = RESET_RESET;
            end else if (branch_taken) begin
                reset_IF_ID = RESET_RESET;
                reset_ID_EX = RESET_RESET;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_IF_ID = 1'b1;
                reset_ID_EX = RESET_RESET;
            end else if (imem_busy) begin
                stall_pc    = 1'b1;
                reset_IF_ID = RESET_RESET;
            end
            // Squash overlays the above; a new redirect still lets the PC load.
            if (state_q == SQUASH) begin
                reset_IF_ID = RESET_RESET;
                if (imem_busy && !branch_taken)
                    stall_pc = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!dmem_busy) begin
            case (state_q)
                RUN:     if (branch_taken && imem_busy) state_d = SQUASH;
                SQUASH:  if (!branch_taken && !imem_busy) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    assign flush_inc = branch_taken && !dmem_busy && !reset;

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clear_i (reset),
        .inc_i   (stall_pc),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clear_i (reset),
        .inc_i   (flush_inc),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_dst;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_regwrite;
    logic        branch_taken, imem_busy, dmem_busy;
    logic        stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    reset_t      reset_IF_ID, reset_ID_EX, reset_MEM_WB;
    logic [31:0] stall_cycles, flush_count;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_dst       (ex_dst),
        .ex_is_load   (ex_is_load),
        .ex_regwrite  (ex_regwrite),
        .branch_taken (branch_taken),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .stall_pc     (stall_pc),
        .stall_IF_ID  (stall_IF_ID),
        .stall_ID_EX  (stall_ID_EX),
        .stall_EX_MEM (stall_EX_MEM),
        .reset_IF_ID  (reset_IF_ID),
        .reset_ID_EX  (reset_ID_EX),
        .reset_MEM_WB (reset_MEM_WB),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // Output bundle: 4 stalls then 3 bubble flags (1 = inject bubble).
    typedef struct packed {
        logic spc, sifid, sidex, sexmem;
        logic bifid, bidex, bmemwb;
    } outs_t;

    // Reference model state
    bit          m_valid = 1'b0;
    bit          m_squash;
    logic [31:0] m_stall, m_flush;

    function automatic outs_t expect_outs(bit sq);
        outs_t o;
        bit lu;
        lu = ex_is_load && ex_regwrite && ex_dst != 0 &&
             ((id_use_rs1 && id_rs1 == ex_dst) || (id_use_rs2 && id_rs2 == ex_dst));
        o = '0;
        if (reset)             o = 7'b0000_111;
        else if (dmem_busy)    o = 7'b1111_001;
        else if (branch_taken) o = 7'b0000_110;
        else if (lu)           o = 7'b1100_010;
        else if (imem_busy)    o = 7'b1000_100;
        if (!reset && sq) begin
            o.bifid = 1'b1;
            if (imem_busy && !branch_taken) o.spc = 1'b1;
        end
        return o;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v, bit inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always @(posedge clk) begin
        outs_t e;
        if (reset) begin
            m_valid  = 1'b1;
            m_squash = 1'b0;
            m_stall  = '0;
            m_flush  = '0;
        end else if (m_valid) begin
            e = expect_outs(m_squash);
            m_stall = sat_inc(m_stall, e.spc);
            if (!dmem_busy) begin
                m_flush = sat_inc(m_flush, branch_taken);
                if (branch_taken)    m_squash = m_squash || imem_busy;
                else if (m_squash)   m_squash = imem_busy;
            end
        end
    end

    always @(negedge clk) begin
        outs_t e, a;
        if (m_valid) begin
            e = expect_outs(m_squash);
            a = {stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                 reset_IF_ID == RESET_RESET, reset_ID_EX == RESET_RESET,
                 reset_MEM_WB == RESET_RESET};
            n_vec += 3;
            if (a !== e) begin
                n_miss++;
                $display("FAIL model_outs t=%0t got=%b want=%b", $time, a, e);
            end
            if (stall_cycles !== m_stall) begin
                n_miss++;
                $display("FAIL model_stall_cycles t=%0t got=%h want=%h", $time, stall_cycles, m_stall);
            end
            if (flush_count !== m_flush) begin
                n_miss++;
                $display("FAIL model_flush_count t=%0t got=%h want=%h", $time, flush_count, m_flush);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_dst = 0; ex_is_load = 0; ex_regwrite = 0;
        branch_taken = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        settle();
        chk("rst_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("rst_bubble_ifid", {31'd0, reset_IF_ID == RESET_RESET}, 32'd1);
        chk("rst_bubble_memwb", {31'd0, reset_MEM_WB == RESET_RESET}, 32'd1);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        tick();
        idle();
        settle();
        chk("idle_outs", {stall_pc, stall_IF_ID, reset_IF_ID, reset_ID_EX, reset_MEM_WB}, 32'd0);

        // Load-use on x5
        ex_is_load = 1; ex_regwrite = 1; ex_dst = 5; id_rs1 = 5; id_use_rs1 = 1;
        settle();
        chk("lu_stall", {stall_pc, stall_IF_ID, reset_ID_EX == RESET_RESET}, 32'h7);
        chk("lu_cnt_before", stall_cycles, 32'd0);
        tick();
        idle();
        settle();
        chk("lu_cnt_after", stall_cycles, 32'd1);
        chk("lu_released", {31'd0, stall_pc}, 32'd0);

        // x0 is never a hazard
        ex_is_load = 1; ex_regwrite = 1; ex_dst = 0; id_rs1 = 0; id_use_rs1 = 1;
        settle();
        chk("x0_outs", {stall_pc, stall_IF_ID, reset_IF_ID, reset_ID_EX, reset_MEM_WB}, 32'd0);
        tick();

        // Branch during an outstanding fetch
        do_reset();
        branch_taken = 1; imem_busy = 1;
        settle();
        chk("br_bubble_ifid", {31'd0, reset_IF_ID == RESET_RESET}, 32'd1);
        chk("br_no_pc_stall", {31'd0, stall_pc}, 32'd0);
        tick();
        branch_taken = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("sq_busy", {stall_pc, reset_IF_ID == RESET_RESET}, 32'h3);
            tick();
        end
        imem_busy = 0;
        settle();
        chk("sq_last", {stall_pc, reset_IF_ID == RESET_RESET}, 32'h1);
        tick();
        settle();
        chk("sq_done", {31'd0, reset_IF_ID == RESET_RESET}, 32'd0);
        chk("sq_flush_cnt", flush_count, 32'd1);
        chk("sq_stall_cnt", stall_cycles, 32'd3);

        // dmem beats everything
        dmem_busy = 1; branch_taken = 1;
        ex_is_load = 1; ex_regwrite = 1; ex_dst = 7; id_rs2 = 7; id_use_rs2 = 1;
        settle();
        chk("dm_stalls", {stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                          reset_MEM_WB == RESET_RESET, reset_IF_ID == RESET_RESET}, 32'h3E);
        tick();
        idle();
        settle();
        chk("dm_flush_unch", flush_count, 32'd1);
        chk("dm_stall_cnt", stall_cycles, 32'd4);
        chk("dm_state_run", {31'd0, reset_IF_ID == RESET_RESET}, 32'd0);

        // Reset while squashing
        branch_taken = 1; imem_busy = 1;
        tick();
        branch_taken = 0;
        settle();
        chk("rs_in_squash", {31'd0, reset_IF_ID == RESET_RESET}, 32'd1);
        tick();
        reset = 1;
        settle();
        chk("rs_outs", {stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                        reset_IF_ID, reset_ID_EX, reset_MEM_WB}, 32'h07);
        tick();
        reset = 0; imem_busy = 0;
        settle();
        chk("rs_run", {31'd0, reset_IF_ID == RESET_RESET}, 32'd0);
        chk("rs_stall_cnt", stall_cycles, 32'd0);
        chk("rs_flush_cnt", flush_count, 32'd0);
        tick();

        // Saturation: preload near the top, held over a non-stalling edge
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        tick();
        release dut.u_stall_cnt.cnt_q;
        imem_busy = 1;
        settle();
        chk("sat_pre", stall_cycles, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) tick();
        settle();
        chk("sat_top", stall_cycles, 32'hFFFF_FFFF);
        imem_busy = 0;
        tick();
        settle();
        chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            dmem_busy    = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            imem_busy    = ($urandom_range(0, 2) != 0);
            ex_is_load   = 1'($urandom_range(0, 1));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_dst       = 5'($urandom_range(0, 3));
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: ID-stage source register indices.
REQ-004 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the ID instruction actually reads that source.
REQ-005 SHALL have ports ex_dst (input, 5 bits), ex_is_load (input, 1 bit) and ex_regwrite (input, 1 bit): destination and kind of the EX-stage instruction.
REQ-006 SHALL have port branch_taken, input, 1 bit: EX resolved a redirect this cycle.
REQ-007 SHALL have port imem_busy, input, 1 bit: a fetch is outstanding.
REQ-008 SHALL have port dmem_busy, input, 1 bit: a data access is outstanding.
REQ-009 SHALL have ports stall_pc, stall_IF_ID, stall_ID_EX and stall_EX_MEM, output, 1 bit each: the register holds its value.
REQ-010 SHALL have ports reset_IF_ID, reset_ID_EX and reset_MEM_WB, output, reset_t: RESET_RESET injects a bubble into that pipeline register.
REQ-011 SHALL have ports stall_cycles and flush_count, output, 32 bits each: performance counters.

Function
REQ-012 Stall and reset_t outputs SHALL be combinational from the inputs and the registered state; the counters SHALL be registered.
REQ-013 Condition priority SHALL be: dmem_busy > branch_taken > load-use > imem_busy > none.
REQ-014 Default outputs SHALL be: all stalls 0 and all reset_t outputs RESET_CONTINUE.
REQ-015 When dmem_busy=1, stall_pc, stall_IF_ID, stall_ID_EX and stall_EX_MEM SHALL be 1 and reset_MEM_WB SHALL be RESET_RESET; state SHALL be unchanged; branch_taken SHALL be ignored that cycle.
REQ-016 Load-use SHALL be defined as: ex_is_load & ex_regwrite & ex_dst!=0 & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst)).
REQ-017 On load-use, stall_pc and stall_IF_ID SHALL be 1 and reset_ID_EX SHALL be RESET_RESET, giving exactly one bubble per occurrence.
REQ-018 On branch_taken, reset_IF_ID and reset_ID_EX SHALL be RESET_RESET and stall_pc SHALL be 0; flush_count SHALL increment next edge.
REQ-019 When imem_busy=1 alone, stall_pc SHALL be 1 and reset_IF_ID SHALL be RESET_RESET.
REQ-020 The FSM SHALL have exactly two states, RUN and SQUASH.
REQ-021 RUN SHALL go to SQUASH when branch_taken=1 and imem_busy=1 in the same cycle and dmem_busy=0; otherwise it SHALL stay in RUN.
REQ-022 While in SQUASH: the stale fetch SHALL be discarded, and reset_IF_ID SHALL be RESET_RESET every cycle.
REQ-023 SQUASH SHALL return to RUN on the first cycle with imem_busy=0, including that cycle's squash.
REQ-024 In SQUASH, stall_pc SHALL be 1 while imem_busy=1.
REQ-025 A branch_taken while in SQUASH SHALL keep the FSM in SQUASH and count as a flush.
REQ-026 stall_cycles SHALL increment on every cycle with stall_pc=1.
REQ-027 Both counters SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-028 Simultaneous load-use and branch_taken SHALL resolve to a branch flush only, with no PC stall.

Reset
REQ-029 While reset=1: all stalls SHALL be 0 and all reset_t outputs RESET_RESET.
REQ-030 On the reset edge: the FSM SHALL go to RUN and both counters SHALL clear to 0.
REQ-031 A reset asserted mid-SQUASH SHALL abandon the squash; the first cycle after reset SHALL be RUN.

Structure
REQ-032 The hazard_state_t enum (RUN, SQUASH) SHALL be added to the pipes package, and reset_t SHALL be reused from pipes.
REQ-033 The counter width SHALL be a pipes constant, PERF_CNT_W = 32.
REQ-034 One sub-module, sat_counter (parameterised width, inc, clear), SHALL be instantiated twice.

Verification
REQ-035 Load-use: ex_is_load=1, ex_regwrite=1, ex_dst=5, id_rs1=5, id_use_rs1=1 -> stall_pc=1, stall_IF_ID=1, reset_ID_EX=RESET_RESET for 1 cycle; stall_cycles goes 0 to 1.
REQ-036 x0 exemption: same stimulus with ex_dst=0 and id_rs1=0 -> no stall, all reset_t outputs RESET_CONTINUE.
REQ-037 Branch during fetch: branch_taken=1 with imem_busy=1, then imem_busy held 3 more cycles, then 0 -> SQUASH for 4 cycles; reset_IF_ID=RESET_RESET on all 5 cycles; RUN next; flush_count=1.
REQ-038 dmem priority: dmem_busy=1 with branch_taken=1 and load-use all true -> four stalls=1, reset_MEM_WB=RESET_RESET, flush_count unchanged, state unchanged.
REQ-039 Saturation: stall_cycles forced to 32'hFFFF_FFFE, then 3 stalled cycles -> reads 32'hFFFF_FFFF and holds.
REQ-040 Reset in SQUASH: reset=1 for 1 cycle while in SQUASH -> RUN, counters 0; with imem_busy=0 afterwards, reset_IF_ID=RESET_CONTINUE.
